shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter: one log2 stage per clock, fixed latency of SHAMT_W cycles.
// Optional rotate support for op 11 is enabled by defining SHIFT_SEQUENCER_ROTATE_EN.
//
// state | meaning
// IDLE  | waiting for a request, result/err driven to zero
// SHIFT | applying stage 2^idx when shamt[idx] is set, idx counts down
// DONE  | result presented until out_ready
module shift_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 op,
    input  logic [WIDTH-1:0]           A,
    input  logic [$clog2(WIDTH)-1:0]   shamt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           result,
    output logic                       err,
    output logic                       busy
);

    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     work_q, work_d;
    logic [1:0]           op_q, op_d;
    logic [SHAMT_W-1:0]   shamt_q, shamt_d;
    logic [SHAMT_W-1:0]   idx_q, idx_d;

    logic [SHAMT_W-1:0]   stage_amt;
    logic [WIDTH-1:0]     stage_val;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    logic [SHAMT_W:0]     rot_amt;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            op_q    <= '0;
            shamt_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            op_q    <= op_d;
            shamt_q <= shamt_d;
            idx_q   <= idx_d;
        end
    end

    // One stage of the barrel: shift by 2^idx when the matching shamt bit is set
    always_comb begin
        stage_amt = SHAMT_W'(1) << idx_q;
        stage_val = work_q;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
        rot_amt   = (SHAMT_W+1)'(WIDTH) - {1'b0, stage_amt};
`endif
        if (shamt_q[idx_q]) begin
            case (op_q)
                OP_SLL:  stage_val = work_q << stage_amt;
                OP_SRL:  stage_val = work_q >> stage_amt;
                OP_SRA:  stage_val = $signed(work_q) >>> stage_amt;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
                OP_ROL:  stage_val = (work_q << stage_amt) | (work_q >> rot_amt);
`endif
                default: stage_val = work_q;
            endcase
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        op_d    = op_q;
        shamt_d = shamt_q;
        idx_d   = idx_q;

        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    work_d  = A;
                    op_d    = op;
                    shamt_d = shamt;
                    idx_d   = SHAMT_W'(SHAMT_W - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = stage_val;
                idx_d  = idx_q - 1'b1;
                if (idx_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    work_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush outranks both accept and out_ready; harmless in IDLE
        if (flush && state_q != IDLE) begin
            state_d = IDLE;
            work_d  = '0;
            op_d    = '0;
            shamt_d = '0;
            idx_d   = '0;
        end
    end

    // Outputs
    always_comb begin
        in_ready  = reset_n && (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == SHIFT) || (state_q == DONE);
        result    = '0;
        err       = 1'b0;
        if (state_q == DONE) begin
            result = work_q;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
            err    = 1'b0;
`else
            err    = (op_q == OP_ROL);
`endif
        end
    end

endmodule
